// File: rtl/ahbl_arbiter2.sv
// Two-master AHB-lite arbiter in front of a single slave port. A master that loses
// arbitration has its address phase parked in a per-master pending register and replayed later.
module ahbl_arbiter2 #(
  parameter int ARB_MODE = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA
);
  localparam int NM = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
  } ap_t;

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} own_e;

  ap_t  [NM-1:0] ap_live, ap_pend;
  logic [NM-1:0] pend, req, hready;
  own_e          arb, grant, grant_q, downer;
  logic          last_m1;
  logic          gsel;
  ap_t           s_ap;

  assign ap_live[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE};
  assign ap_live[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE};

  // SEQ beats lock the bus to the current grantee so bursts are never interleaved.
  always_comb begin
    arb = OWN_NONE;
    if (grant_q == OWN_M0 && !pend[0] && ap_live[0].trans == 2'b11)
      arb = OWN_M0;
    else if (grant_q == OWN_M1 && !pend[1] && ap_live[1].trans == 2'b11)
      arb = OWN_M1;
    else if (ARB_MODE == 1) begin
      if (req[1])      arb = OWN_M1;
      else if (req[0]) arb = OWN_M0;
    end else if (req[0] && req[1])
      arb = last_m1 ? OWN_M0 : OWN_M1;
    else if (req[0])
      arb = OWN_M0;
    else if (req[1])
      arb = OWN_M1;
  end

  // Re-arbitrate only in cycles where the slave accepts; during a wait state the grant is frozen.
  assign grant = !HRESETn ? OWN_NONE : (S_HREADYOUT ? arb : grant_q);

  for (genvar g = 0; g < NM; g++) begin : g_port
    localparam own_e ME = (g == 0) ? OWN_M0 : OWN_M1;
    logic granted, owner, pend_r;
    ap_t  ap_r;

    assign granted   = (grant == ME);
    assign owner     = (downer == ME);
    assign req[g]    = pend_r | ap_live[g].trans[1];
    assign hready[g] = owner ? S_HREADYOUT : (pend_r ? 1'b0 : (granted ? S_HREADYOUT : 1'b1));
    assign pend[g]   = pend_r;
    assign ap_pend[g] = ap_r;

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        pend_r <= 1'b0;
        ap_r   <= '0;
      end else if (!granted && !pend_r && ap_live[g].trans[1] && hready[g]) begin
        pend_r <= 1'b1;
        ap_r   <= ap_live[g];
      end else if (granted && pend_r && S_HREADYOUT) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign gsel = (grant == OWN_M1);

  // A replayed transfer starts a new sequence on the slave, so it always goes out as NONSEQ.
  always_comb begin
    s_ap = '0;
    if (grant != OWN_NONE) begin
      s_ap = pend[gsel] ? ap_pend[gsel] : ap_live[gsel];
      if (pend[gsel]) s_ap.trans = 2'b10;
    end
  end

  assign S_HADDR  = s_ap.addr;
  assign S_HTRANS = s_ap.trans;
  assign S_HWRITE = s_ap.write;
  assign S_HSIZE  = s_ap.size;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q <= OWN_NONE;
      downer  <= OWN_NONE;
      last_m1 <= 1'b1;
    end else if (S_HREADYOUT) begin
      grant_q <= grant;
      if (s_ap.trans[1]) begin
        downer  <= grant;
        last_m1 <= (grant == OWN_M1);
      end else begin
        downer  <= OWN_NONE;
      end
    end
  end

  always_comb begin
    S_HWDATA = '0;
    case (downer)
      OWN_M0:  S_HWDATA = M0_HWDATA;
      OWN_M1:  S_HWDATA = M1_HWDATA;
      default: S_HWDATA = '0;
    endcase
  end

  assign M0_HREADY = hready[0];
  assign M1_HREADY = hready[1];
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign S_HREADY  = S_HREADYOUT;

endmodule

// File: tb/tb_ahbl_arbiter2.sv
// Directed bench for ahbl_arbiter2: one round-robin and one fixed-priority instance share
// the same master/slave stimulus; each vector checks hand-derived outputs.
module tb_ahbl_arbiter2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m0_haddr = '0, m1_haddr = '0, m0_hwdata = '0, m1_hwdata = '0;
  logic [1:0]  m0_htrans = '0, m1_htrans = '0;
  logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
  logic [2:0]  m0_hsize = 3'd2, m1_hsize = 3'd2;
  logic        s_hreadyout = 1'b1;
  logic [31:0] s_hrdata = '0;

  logic        m0_hready, m1_hready, s_hwrite, s_hready;
  logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize;

  logic        b_m0_hready, b_m1_hready, b_s_hwrite, b_s_hready;
  logic [31:0] b_m0_hrdata, b_m1_hrdata, b_s_haddr, b_s_hwdata;
  logic [1:0]  b_s_htrans;
  logic [2:0]  b_s_hsize;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ahbl_arbiter2 #(.ARB_MODE(0)) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready), .M0_HRDATA(m0_hrdata),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready), .M1_HRDATA(m1_hrdata),
    .S_HADDR(s_haddr), .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite), .S_HSIZE(s_hsize),
    .S_HWDATA(s_hwdata), .S_HREADY(s_hready), .S_HREADYOUT(s_hreadyout), .S_HRDATA(s_hrdata)
  );

  ahbl_arbiter2 #(.ARB_MODE(1)) dut_fp (
    .HCLK(clk), .HRESETn(rst_n),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HWDATA(m0_hwdata), .M0_HREADY(b_m0_hready), .M0_HRDATA(b_m0_hrdata),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HWDATA(m1_hwdata), .M1_HREADY(b_m1_hready), .M1_HRDATA(b_m1_hrdata),
    .S_HADDR(b_s_haddr), .S_HTRANS(b_s_htrans), .S_HWRITE(b_s_hwrite), .S_HSIZE(b_s_hsize),
    .S_HWDATA(b_s_hwdata), .S_HREADY(b_s_hready), .S_HREADYOUT(s_hreadyout), .S_HRDATA(s_hrdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic m0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
    m0_htrans = t; m0_haddr = a; m0_hwrite = w; m0_hwdata = d;
  endtask

  task automatic m1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
    m1_htrans = t; m1_haddr = a; m1_hwrite = w; m1_hwdata = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset: outputs forced idle even while a master drives NONSEQ
    #3;
    m0(2'b10, 32'hDEAD_0000, 1'b1, 32'h5555);
    #1;
    chk("rst_htrans", 32'(s_htrans), 32'h0);
    chk("rst_m0_hready", 32'(m0_hready), 32'h1);
    chk("rst_m1_hready", 32'(m1_hready), 32'h1);
    chk("rst_hwdata", s_hwdata, 32'h0);
    m0(2'b00, 32'h0, 1'b0, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // uncontended single write, zero added latency
    m0(2'b10, 32'h4000_0000, 1'b1, 32'h1111);
    #1;
    chk("solo_haddr", s_haddr, 32'h4000_0000);
    chk("solo_htrans", 32'(s_htrans), 32'h2);
    chk("solo_hwrite", 32'(s_hwrite), 32'h1);
    chk("solo_hsize", 32'(s_hsize), 32'h2);
    chk("solo_m0_hready", 32'(m0_hready), 32'h1);
    chk("solo_m1_hready", 32'(m1_hready), 32'h1);
    cyc();
    m0(2'b00, 32'h0, 1'b0, 32'h1111);
    s_hrdata = 32'hCAFE_F00D;
    #1;
    chk("solo_dph_hwdata", s_hwdata, 32'h1111);
    chk("solo_dph_m0_hready", 32'(m0_hready), 32'h1);
    chk("solo_dph_htrans", 32'(s_htrans), 32'h0);
    chk("hrdata_m0", m0_hrdata, 32'hCAFE_F00D);
    chk("hrdata_m1", m1_hrdata, 32'hCAFE_F00D);
    cyc();

    // simultaneous NONSEQ after reset, both arbitration modes
    do_reset();
    m0(2'b10, 32'h10, 1'b1, 32'hA0);
    m1(2'b10, 32'h20, 1'b1, 32'hB0);
    #1;
    chk("rr_first_addr", s_haddr, 32'h10);
    chk("rr_m1_captured_hready", 32'(m1_hready), 32'h1);
    chk("fp_first_addr", b_s_haddr, 32'h20);
    chk("fp_m0_captured_hready", 32'(b_m0_hready), 32'h1);
    cyc();
    m0(2'b00, 32'h0, 1'b0, 32'hA0);
    m1(2'b00, 32'h0, 1'b0, 32'hB0);
    #1;
    chk("rr_second_addr", s_haddr, 32'h20);
    chk("rr_second_htrans", 32'(s_htrans), 32'h2);
    chk("rr_m1_hready_pend", 32'(m1_hready), 32'h0);
    chk("rr_m0_hready_dph", 32'(m0_hready), 32'h1);
    chk("rr_hwdata_m0", s_hwdata, 32'hA0);
    chk("fp_second_addr", b_s_haddr, 32'h10);
    chk("fp_m0_hready_pend", 32'(b_m0_hready), 32'h0);
    chk("fp_hwdata_m1", b_s_hwdata, 32'hB0);
    cyc();
    #1;
    chk("rr_hwdata_m1", s_hwdata, 32'hB0);
    chk("rr_m1_hready_dph", 32'(m1_hready), 32'h1);
    chk("rr_idle_after", 32'(s_htrans), 32'h0);
    chk("fp_hwdata_m0", b_s_hwdata, 32'hA0);
    cyc();

    // M1 4-beat INCR with M0 arriving at beat 2: no interleave
    m1(2'b10, 32'h100, 1'b0, 32'h0);
    #1;
    chk("burst_b1", s_haddr, 32'h100);
    cyc();
    m1(2'b11, 32'h104, 1'b0, 32'h0);
    m0(2'b10, 32'h200, 1'b1, 32'hE0);
    #1;
    chk("burst_b2", s_haddr, 32'h104);
    chk("burst_m0_captured", 32'(m0_hready), 32'h1);
    cyc();
    m1(2'b11, 32'h108, 1'b0, 32'h0);
    m0(2'b00, 32'h0, 1'b0, 32'hE0);
    #1;
    chk("burst_b3", s_haddr, 32'h108);
    chk("burst_b3_htrans", 32'(s_htrans), 32'h3);
    chk("burst_m0_wait_b3", 32'(m0_hready), 32'h0);
    cyc();
    m1(2'b11, 32'h10C, 1'b0, 32'h0);
    #1;
    chk("burst_b4", s_haddr, 32'h10C);
    chk("burst_m0_wait_b4", 32'(m0_hready), 32'h0);
    cyc();
    m1(2'b00, 32'h0, 1'b0, 32'h0);
    #1;
    chk("burst_m0_issued", s_haddr, 32'h200);
    chk("burst_m0_nonseq", 32'(s_htrans), 32'h2);
    cyc();
    #1;
    chk("burst_m0_dph_hwdata", s_hwdata, 32'hE0);
    chk("burst_done_idle", 32'(s_htrans), 32'h0);
    cyc();

    // slave wait states during M0 data phase with M1 arriving
    m0(2'b10, 32'h300, 1'b1, 32'hC3);
    #1;
    chk("ws_m0_addr", s_haddr, 32'h300);
    cyc();
    m0(2'b00, 32'h0, 1'b0, 32'hC3);
    m1(2'b10, 32'h400, 1'b1, 32'hD4);
    s_hreadyout = 1'b0;
    #1;
    chk("ws1_htrans", 32'(s_htrans), 32'h0);
    chk("ws1_m1_captured", 32'(m1_hready), 32'h1);
    chk("ws1_m0_hready", 32'(m0_hready), 32'h0);
    chk("ws1_hwdata", s_hwdata, 32'hC3);
    cyc();
    m1(2'b00, 32'h0, 1'b0, 32'hD4);
    #1;
    chk("ws2_m1_hready", 32'(m1_hready), 32'h0);
    chk("ws2_htrans", 32'(s_htrans), 32'h0);
    cyc();
    #1;
    chk("ws3_hwdata", s_hwdata, 32'hC3);
    chk("ws3_m0_hready", 32'(m0_hready), 32'h0);
    cyc();
    s_hreadyout = 1'b1;
    #1;
    chk("ws_m1_issued", s_haddr, 32'h400);
    chk("ws_m1_nonseq", 32'(s_htrans), 32'h2);
    chk("ws_m1_hwrite", 32'(s_hwrite), 32'h1);
    chk("ws_m0_done", 32'(m0_hready), 32'h1);
    chk("ws_m1_still_wait", 32'(m1_hready), 32'h0);
    cyc();
    #1;
    chk("ws_m1_hwdata", s_hwdata, 32'hD4);
    chk("ws_m1_hready_dph", 32'(m1_hready), 32'h1);
    cyc();

    // reset while M1 holds a pending transfer: discarded, never replayed
    m0(2'b10, 32'h10, 1'b0, 32'h0);
    m1(2'b10, 32'h20, 1'b0, 32'h0);
    cyc();
    m0(2'b00, 32'h0, 1'b0, 32'h0);
    m1(2'b00, 32'h0, 1'b0, 32'h0);
    #1;
    chk("prerst_m1_pend", 32'(m1_hready), 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_m1_hready", 32'(m1_hready), 32'h1);
    chk("midrst_htrans", 32'(s_htrans), 32'h0);
    chk("midrst_hwdata", s_hwdata, 32'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("postrst_idle%0d", i), 32'(s_htrans), 32'h0);
      chk($sformatf("postrst_m1_hready%0d", i), 32'(m1_hready), 32'h1);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
